// File: rtl/gpioemu_host_ctrl_pkg.sv
// Shared definitions for the gpioemu host sequencer.
//   - register offsets from BASE_ADDR (DATA, STATE, RESULT, CTRL)
//   - CTRL command codes and STATE status codes
//   - sequencer FSM state type (also exported on the debug port)
package gpioemu_host_ctrl_pkg;

    localparam logic [15:0] OFS_DATA   = 16'd0;
    localparam logic [15:0] OFS_STATE  = 16'd8;
    localparam logic [15:0] OFS_RESULT = 16'd16;
    localparam logic [15:0] OFS_CTRL   = 16'd24;

    localparam logic [31:0] CMD_PUT = 32'd1;
    localparam logic [31:0] CMD_GET = 32'd2;
    localparam logic [31:0] CMD_CLR = 32'd3;

    localparam logic [31:0] ST_READY = 32'd3;
    localparam logic [31:0] ST_ERR   = 32'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_W,
        S_DATA_W,
        S_PUT_W,
        S_GET_W,
        S_POLL_GAP,
        S_POLL_R,
        S_POLL_S,
        S_RES_R,
        S_RES_S,
        S_DONE,
        S_GAP
    } state_t;

endpackage

// File: rtl/gpioemu_host_ctrl_if.sv
// Register bus between the host sequencer (master) and the gpioemu slave.
//   m_address : register address, valid with the strobe, held until the next one
//   m_wr/m_rd : single-cycle write / read strobes, never together
//   m_wdata   : write data, valid with m_wr
//   m_rdata   : read data, registered by the slave on the edge ending the m_rd cycle
interface gpioemu_host_ctrl_if;

    logic [15:0] m_address;
    logic        m_wr;
    logic        m_rd;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (
        output m_address,
        output m_wr,
        output m_rd,
        output m_wdata,
        input  m_rdata
    );

    modport slave (
        input  m_address,
        input  m_wr,
        input  m_rd,
        input  m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/gpioemu_host_ctrl.sv
// gpioemu_host_ctrl: bus-master sequencer feeding message bytes to gpioemu.
// Per message: CLR (first byte only), DATA write + PUT per byte, GET, poll
// STATE until ready/error (or timeout), read RESULT, present the digest.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready : message byte stream (input side)
//   cmd_clr             : one-cycle standalone CLR request, honoured in IDLE only
//   bus (master)        : gpioemu register bus
//   res_data/res_err/res_valid/res_ready : digest result (output side)
//   busy                : FSM not in IDLE
//   dbg_state           : current FSM state
//
// Handshakes: a stream transfer happens on every rising edge where valid and
// ready are both high; valid, once raised, holds its payload until that edge
// (res_valid/res_data/res_err are held until res_ready is seen).
module gpioemu_host_ctrl
    import gpioemu_host_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR     = 16'h0640,
    parameter int          MAX_BYTES     = 250,
    parameter int          POLL_GAP      = 4,
    parameter int          TIMEOUT_POLLS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                cmd_clr,
    gpioemu_host_ctrl_if.master bus,
    output logic [31:0]         res_data,
    output logic                res_err,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output state_t              dbg_state
);

    localparam int          PW     = $clog2(TIMEOUT_POLLS + 1);
    localparam int          WW     = $clog2(POLL_GAP + 1);
    localparam logic [7:0]  MAXC   = 8'(MAX_BYTES);
    localparam logic [PW-1:0] TOUT = PW'(TIMEOUT_POLLS);
    localparam logic [WW-1:0] WLAST = WW'(POLL_GAP - 1);

    state_t          state;
    state_t          gap_next;   // state entered after the GAP cycle
    logic [7:0]      count;
    logic            ovf;
    logic [7:0]      byte_q;
    logic            last_q;
    logic [PW-1:0]   poll_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            st_err;

    logic [15:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            wr_q;
    logic            rd_q;

    assign bus.m_address = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wr      = wr_q;
    assign bus.m_rd      = rd_q;

    // cmd_clr wins over a byte in the same IDLE cycle, so ready drops then.
    assign s_ready   = (state == S_IDLE) && !cmd_clr && !reset;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Strobes are asserted on the transition into a *_W / *_R state, so the
    // strobe cycle is exactly the cycle the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            gap_next  <= S_IDLE;
            count     <= '0;
            ovf       <= 1'b0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            poll_cnt  <= '0;
            wait_cnt  <= '0;
            st_err    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_clr) begin
                        count    <= '0;
                        ovf      <= 1'b0;
                        gap_next <= S_IDLE;
                        state    <= S_CLR_W;
                        wr_q     <= 1'b1;
                        addr_q   <= BASE_ADDR + OFS_CTRL;
                        wdata_q  <= CMD_CLR;
                    end else if (s_valid) begin
                        byte_q <= s_data;
                        last_q <= s_last;
                        if (count == 8'd0) begin
                            // First byte of a message: clear the slave first.
                            gap_next <= S_DATA_W;
                            state    <= S_CLR_W;
                            wr_q     <= 1'b1;
                            addr_q   <= BASE_ADDR + OFS_CTRL;
                            wdata_q  <= CMD_CLR;
                        end else if (count == MAXC) begin
                            // Overflow byte: swallowed, only flagged.
                            ovf <= 1'b1;
                            if (s_last) begin
                                poll_cnt <= '0;
                                state    <= S_GET_W;
                                wr_q     <= 1'b1;
                                addr_q   <= BASE_ADDR + OFS_CTRL;
                                wdata_q  <= CMD_GET;
                            end
                        end else begin
                            state   <= S_DATA_W;
                            wr_q    <= 1'b1;
                            addr_q  <= BASE_ADDR + OFS_DATA;
                            wdata_q <= {24'b0, s_data};
                        end
                    end
                end

                S_CLR_W:  state <= S_GAP;

                S_DATA_W: begin
                    gap_next <= S_PUT_W;
                    state    <= S_GAP;
                end

                S_GAP: begin
                    state <= gap_next;
                    case (gap_next)
                        S_DATA_W: begin
                            wr_q    <= 1'b1;
                            addr_q  <= BASE_ADDR + OFS_DATA;
                            wdata_q <= {24'b0, byte_q};
                        end
                        S_PUT_W: begin
                            wr_q    <= 1'b1;
                            addr_q  <= BASE_ADDR + OFS_CTRL;
                            wdata_q <= CMD_PUT;
                        end
                        S_GET_W: begin
                            poll_cnt <= '0;
                            wr_q     <= 1'b1;
                            addr_q   <= BASE_ADDR + OFS_CTRL;
                            wdata_q  <= CMD_GET;
                        end
                        default: ;
                    endcase
                end

                S_PUT_W: begin
                    count <= (count == MAXC) ? count : count + 8'd1;
                    if (last_q) begin
                        gap_next <= S_GET_W;
                        state    <= S_GAP;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_GET_W: begin
                    wait_cnt <= '0;
                    state    <= S_POLL_GAP;
                end

                S_POLL_GAP: begin
                    if (wait_cnt == WLAST) begin
                        poll_cnt <= poll_cnt + 1'b1;
                        state    <= S_POLL_R;
                        rd_q     <= 1'b1;
                        addr_q   <= BASE_ADDR + OFS_STATE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_POLL_R: state <= S_POLL_S;

                S_POLL_S: begin
                    if (bus.m_rdata == ST_READY || bus.m_rdata == ST_ERR) begin
                        st_err <= (bus.m_rdata == ST_ERR);
                        state  <= S_RES_R;
                        rd_q   <= 1'b1;
                        addr_q <= BASE_ADDR + OFS_RESULT;
                    end else if (poll_cnt == TOUT) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_POLL_GAP;
                    end
                end

                S_RES_R: state <= S_RES_S;

                S_RES_S: begin
                    res_data  <= bus.m_rdata;
                    res_err   <= st_err | ovf;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpioemu_host_ctrl.sv
// Directed bench for gpioemu_host_ctrl with a behavioural gpioemu slave
// (CRC-32C digest, STATE busy for a few cycles after GET).
module tb_gpioemu_host_ctrl;
    import gpioemu_host_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        cmd_clr = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    state_t      dbg_state;

    gpioemu_host_ctrl_if bus();

    gpioemu_host_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .cmd_clr   (cmd_clr),
        .bus       (bus),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- slave model ----------------
    logic [7:0]  sl_data = '0;
    logic [31:0] sl_crc = 32'hdeadbeef;
    logic [31:0] sl_state = '0;
    int          sl_busy = 0;
    logic        sl_hang = 1'b0;
    logic [31:0] rdata_q = '0;
    int          wr_cnt = 0, rd_cnt = 0, put_cnt = 0, clr_cnt = 0, viol_cnt = 0;
    logic [15:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        prev_strobe = 1'b0;

    assign bus.m_rdata = rdata_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'b0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'h82F63B78) : (r >> 1);
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            sl_state <= '0;
            sl_crc   <= 32'hdeadbeef;   // stale digest unless the host clears
            sl_busy  <= 0;
            rdata_q  <= '0;
        end else begin
            if (sl_state == 32'd1 && !sl_hang) begin
                if (sl_busy == 0) sl_state <= ST_READY;
                else sl_busy <= sl_busy - 1;
            end
            if (bus.m_wr) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= bus.m_address;
                last_wr_data <= bus.m_wdata;
                if (bus.m_address == 16'h0640) sl_data <= bus.m_wdata[7:0];
                if (bus.m_address == 16'h0658) begin
                    if (bus.m_wdata == CMD_PUT) begin
                        put_cnt <= put_cnt + 1;
                        sl_crc  <= crc_byte(sl_crc, sl_data);
                    end else if (bus.m_wdata == CMD_GET) begin
                        sl_state <= 32'd1;
                        sl_busy  <= 10;
                    end else if (bus.m_wdata == CMD_CLR) begin
                        clr_cnt  <= clr_cnt + 1;
                        sl_crc   <= 32'hffffffff;
                        sl_state <= '0;
                    end
                end
            end
            if (bus.m_rd) begin
                rd_cnt  <= rd_cnt + 1;
                rdata_q <= (bus.m_address == 16'h0648) ? sl_state :
                           (bus.m_address == 16'h0650) ? ~sl_crc : 32'h0;
            end
        end
        // strobe protocol monitor: no overlap, no back-to-back strobes
        if ((bus.m_wr && bus.m_rd) || ((bus.m_wr || bus.m_rd) && prev_strobe))
            viol_cnt <= viol_cnt + 1;
        prev_strobe <= bus.m_wr | bus.m_rd;
    end

    // ---------------- scoreboard / checks ----------------
    int tests = 0;
    int failed = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        s_data = b; s_valid = 1'b1; s_last = last;
        while (s_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check32("s_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_fill(input logic [7:0] b, input int len);
        for (int i = 0; i < len; i++) send_byte(b, i == len - 1);
    endtask

    task automatic wait_res(input string tag, input logic [31:0] exp_d,
                            input logic exp_e, input int hold);
        int n, w0, r0;
        n = 0;
        while (res_valid !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        check32({tag, "_valid"}, 32'(res_valid), 32'd1);
        check32({tag, "_data"}, res_data, exp_d);
        check32({tag, "_err"}, 32'(res_err), 32'(exp_e));
        w0 = wr_cnt; r0 = rd_cnt;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check32({tag, "_hold"}, {res_data[31:3], res_valid, s_ready, bus.m_wr | bus.m_rd},
                    {exp_d[31:3], 3'b100});
        end
        if (hold > 0) check32({tag, "_hold_bus"}, 32'(wr_cnt + rd_cnt - w0 - r0), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check32({tag, "_idle"}, {30'b0, res_valid, busy}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int w0, p0, c0, r0, n;

    initial begin
        repeat (4) @(negedge clk);
        check32("rst_outputs", {25'b0, s_ready, busy, bus.m_wr, bus.m_rd, res_valid, res_err, 1'b0}, 32'd0);
        check32("rst_addr", {bus.m_address, 16'b0}, 32'd0);
        check32("rst_state", 32'(dbg_state), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);
        check32("rst_release_ready", 32'(s_ready), 32'd1);

        // standalone CLR from IDLE
        w0 = wr_cnt;
        cmd_clr = 1'b1;
        #1 check32("clr_sready_low", 32'(s_ready), 32'd0);
        @(negedge clk);
        cmd_clr = 1'b0;
        repeat (4) @(negedge clk);
        check32("clr_wr_count", 32'(wr_cnt - w0), 32'd1);
        check32("clr_addr", {16'b0, last_wr_addr}, 32'h0658);
        check32("clr_data", last_wr_data, 32'd3);

        // ac dc, with cmd_clr pulsed while busy (must be ignored)
        w0 = wr_cnt; p0 = put_cnt; c0 = clr_cnt;
        send_byte(8'hac, 1'b0);
        cmd_clr = 1'b1;
        @(negedge clk);
        cmd_clr = 1'b0;
        send_byte(8'hdc, 1'b1);
        wait_res("acdc", 32'h3827e236, 1'b0, 0);
        check32("acdc_writes", 32'(wr_cnt - w0), 32'd6);
        check32("acdc_puts", 32'(put_cnt - p0), 32'd2);
        check32("acdc_clrs", 32'(clr_cnt - c0), 32'd1);

        send_byte(8'h53, 1'b0); send_byte(8'h18, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h80, 1'b1);
        wait_res("msg4", 32'ha2825413, 1'b0, 0);

        send_byte(8'h00, 1'b1);
        wait_res("zero1", 32'h527d5351, 1'b0, 0);

        send_fill(8'h00, 4);
        wait_res("zero4", 32'h48674bc7, 1'b0, 0);

        p0 = put_cnt;
        send_fill(8'h11, 250);
        wait_res("fill250", 32'h3c96196e, 1'b0, 0);
        check32("fill250_puts", 32'(put_cnt - p0), 32'd250);

        p0 = put_cnt;
        send_fill(8'h11, 251);
        wait_res("fill251", 32'h3c96196e, 1'b1, 0);
        check32("fill251_puts", 32'(put_cnt - p0), 32'd250);

        // reset while polling
        r0 = rd_cnt;
        send_byte(8'hac, 1'b0);
        send_byte(8'hdc, 1'b1);
        n = 0;
        while (rd_cnt == r0 && n < 500) begin @(negedge clk); n++; end
        check32("poll_started", 32'(rd_cnt != r0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check32("midrst_outputs", {26'b0, s_ready, busy, bus.m_wr, bus.m_rd, res_valid, res_err}, 32'd0);
        check32("midrst_addr", {bus.m_address, 16'b0}, 32'd0);
        check32("midrst_wdata", bus.m_wdata, 32'd0);
        check32("midrst_resdata", res_data, 32'd0);
        reset = 1'b0;
        send_byte(8'hac, 1'b0);
        send_byte(8'hdc, 1'b1);
        wait_res("after_rst", 32'h3827e236, 1'b0, 0);

        // result held while res_ready is low
        send_byte(8'h00, 1'b1);
        wait_res("hold20", 32'h527d5351, 1'b0, 20);

        // slave never ready: timeout after the full poll budget
        sl_hang = 1'b1;
        r0 = rd_cnt;
        send_byte(8'h00, 1'b1);
        wait_res("timeout", 32'h0, 1'b1, 0);
        check32("timeout_polls", 32'(rd_cnt - r0), 32'd1024);
        sl_hang = 1'b0;

        repeat (3) @(negedge clk);
        check32("strobe_protocol", 32'(viol_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
